// File: rtl/missile_ctl_pkg.sv
// rtl/missile_ctl_pkg.sv - shared missile state encodings, coordinate width and defaults
package missile_ctl_pkg;

  localparam int COORD_W         = 11;
  localparam int CNT_W           = 16;
  localparam int DEF_SPEED       = 8;
  localparam int DEF_MISSILE_H   = 20;
  localparam int DEF_COOLDOWN_FR = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLY      = 2'd1,
    ST_COOLDOWN = 2'd2
  } missile_state_t;

  // Coordinates never wrap: anything that would go negative saturates at 0.
  function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/missile_ctl_rise_edge.sv
// rtl/missile_ctl_rise_edge.sv - one-register rising-edge detector for fire and vsync
module missile_ctl_rise_edge (
  input  logic pclk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/missile_ctl.sv
// rtl/missile_ctl.sv - single-missile launch/flight/cooldown controller
// AUTOFIRE_EN: when defined, a held fire level relaunches from IDLE.
module missile_ctl
  import missile_ctl_pkg::*;
#(
  parameter int SPEED       = DEF_SPEED,
  parameter int MISSILE_H   = DEF_MISSILE_H,
  parameter int COOLDOWN_FR = DEF_COOLDOWN_FR
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               fire,
  input  logic               hit,
  input  logic               vsync_in,
  input  logic [COORD_W-1:0] ship_xpos,
  input  logic [COORD_W-1:0] ship_ypos,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               on,
  output logic               ready
);

  localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(MISSILE_H);
  localparam logic [CNT_W-1:0] CD_LAST = (COOLDOWN_FR == 0) ? '0 : CNT_W'(COOLDOWN_FR - 1);

  logic fire_rise;
  logic tick;
  logic launch;
  logic fly_end;

  missile_ctl_rise_edge u_fire_edge (
    .pclk (pclk),
    .rst  (rst),
    .d    (fire),
    .rise (fire_rise)
  );

  missile_ctl_rise_edge u_vsync_edge (
    .pclk (pclk),
    .rst  (rst),
    .d    (vsync_in),
    .rise (tick)
  );

`ifdef AUTOFIRE_EN
  assign launch = fire | fire_rise;
`else
  assign launch = fire_rise;
`endif

  // Hit outranks a same-cycle tick, so ypos is left untouched on a hit.
  assign fly_end = hit | (tick & (ypos < SPEED_C));

  missile_state_t    state;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      xpos  <= '0;
      ypos  <= '0;
      on    <= 1'b0;
      ready <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            xpos  <= ship_xpos;
            ypos  <= sat_sub(ship_ypos, HEIGHT_C);
            on    <= 1'b1;
            ready <= 1'b0;
            state <= ST_FLY;
          end
        end
        ST_FLY: begin
          if (fly_end) begin
            on  <= 1'b0;
            cnt <= '0;
            if (COOLDOWN_FR == 0) begin
              ready <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_COOLDOWN;
            end
          end else if (tick) begin
            ypos <= sat_sub(ypos, SPEED_C);
          end
        end
        ST_COOLDOWN: begin
          if (tick) begin
            if (cnt == CD_LAST) begin
              ready <= 1'b1;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          on    <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_missile_ctl.sv
// tb/tb_missile_ctl.sv - randomized + directed bench for missile_ctl against a frame-level model
module tb_missile_ctl;

  localparam int SPEED = 8;
  localparam int MISSILE_H = 20;
  localparam int COOLDOWN_FR = 10;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        fire = 1'b0;
  logic        hit = 1'b0;
  logic        vsync_in = 1'b0;
  logic [10:0] ship_xpos = '0;
  logic [10:0] ship_ypos = '0;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        on;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  missile_ctl #(
    .SPEED       (SPEED),
    .MISSILE_H   (MISSILE_H),
    .COOLDOWN_FR (COOLDOWN_FR)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .fire      (fire),
    .hit       (hit),
    .vsync_in  (vsync_in),
    .ship_xpos (ship_xpos),
    .ship_ypos (ship_ypos),
    .xpos      (xpos),
    .ypos      (ypos),
    .on        (on),
    .ready     (ready)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a missile is either absent-and-launchable, flying at
  // some height, or waiting out a number of remaining frames.
  int  m_x = 0, m_y = 0;
  bit  m_on = 0, m_ready = 1;
  int  frames_left = 0;
  bit  prev_fire = 0, prev_vs = 0;
  bit  m_rise, m_tick, m_launch;

  task automatic model_compare();
    check("model_on", int'(on), int'(m_on));
    check("model_ready", int'(ready), int'(m_ready));
    check("model_xpos", int'(xpos), m_x);
    check("model_ypos", int'(ypos), m_y);
  endtask

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m_x = 0; m_y = 0; m_on = 0; m_ready = 1; frames_left = 0;
      prev_fire = 0; prev_vs = 0;
    end else begin
      m_rise = fire && !prev_fire;
      m_tick = vsync_in && !prev_vs;
      prev_fire = fire;
      prev_vs = vsync_in;
`ifdef AUTOFIRE_EN
      m_launch = fire;
`else
      m_launch = m_rise;
`endif
      if (m_ready) begin
        if (m_launch) begin
          m_x = int'(ship_xpos);
          m_y = (int'(ship_ypos) >= MISSILE_H) ? int'(ship_ypos) - MISSILE_H : 0;
          m_on = 1;
          m_ready = 0;
        end
      end else if (m_on) begin
        if (hit || (m_tick && m_y < SPEED)) begin
          m_on = 0;
          frames_left = COOLDOWN_FR;
          if (frames_left == 0) m_ready = 1;
        end else if (m_tick) begin
          m_y = m_y - SPEED;
        end
      end else if (m_tick) begin
        frames_left = frames_left - 1;
        if (frames_left == 0) m_ready = 1;
      end
    end
    #1 model_compare();
  end

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic frame_tick();
    vsync_in = 1'b1;
    step(2);
    vsync_in = 1'b0;
    step(2);
  endtask

  task automatic pulse_fire();
    fire = 1'b1;
    step(1);
    fire = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    check("reset_on", int'(on), 0);
    check("reset_ready", int'(ready), 1);
    check("reset_xpos", int'(xpos), 0);
    check("reset_ypos", int'(ypos), 0);
    rst = 1'b0;
    step(2);

    // Launch from (400,700), then climb to the top and cool down
    ship_xpos = 11'd400;
    ship_ypos = 11'd700;
    pulse_fire();
    check("launch_on", int'(on), 1);
    check("launch_xpos", int'(xpos), 400);
    check("launch_ypos", int'(ypos), 680);
    check("launch_ready", int'(ready), 0);
    for (int i = 0; i < 85; i++) begin
      if (i == 10) begin
        ship_xpos = 11'd123;
        pulse_fire();
      end
      frame_tick();
    end
    check("top_ypos", int'(ypos), 0);
    check("top_on", int'(on), 1);
    frame_tick();
    check("top_end_on", int'(on), 0);
    check("top_end_ready", int'(ready), 0);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) pulse_fire();
      frame_tick();
    end
    check("cool9_ready", int'(ready), 0);
    frame_tick();
    check("cool10_ready", int'(ready), 1);
    check("frozen_xpos", int'(xpos), 400);
    step(2);

    // Hit and tick in the same cycle at ypos 400
    ship_ypos = 11'd420;
    pulse_fire();
    check("hit_launch_ypos", int'(ypos), 400);
    hit = 1'b1;
    vsync_in = 1'b1;
    step(1);
    hit = 1'b0;
    check("hit_on", int'(on), 0);
    check("hit_ypos", int'(ypos), 400);
    step(1);
    vsync_in = 1'b0;
    step(2);
    repeat (COOLDOWN_FR) frame_tick();
    check("hit_cool_ready", int'(ready), 1);

    // Ship too close to the top: ypos clamps to 0 but launch still occurs
    ship_ypos = 11'd10;
    pulse_fire();
    check("clamp_on", int'(on), 1);
    check("clamp_ypos", int'(ypos), 0);
    frame_tick();
    check("clamp_end_on", int'(on), 0);
    repeat (COOLDOWN_FR) frame_tick();
    check("clamp_cool_ready", int'(ready), 1);

    // Fire held across a full flight + cooldown
    ship_ypos = 11'd36;
    fire = 1'b1;
    step(1);
    check("hold_launch_ypos", int'(ypos), 16);
    repeat (3) frame_tick();
    check("hold_end_on", int'(on), 0);
    repeat (COOLDOWN_FR) frame_tick();
    step(2);
`ifdef AUTOFIRE_EN
    check("hold_refire_on", int'(on), 1);
    check("hold_refire_ready", int'(ready), 0);
    check("hold_refire_ypos", int'(ypos), 16);
`else
    check("hold_norefire_on", int'(on), 0);
    check("hold_norefire_ready", int'(ready), 1);
`endif
    fire = 1'b0;
    repeat (3 + COOLDOWN_FR) frame_tick();
    check("hold_settle_ready", int'(ready), 1);

    // Async reset between clocks mid-flight
    ship_xpos = 11'd400;
    ship_ypos = 11'd700;
    pulse_fire();
    frame_tick();
    frame_tick();
    check("pre_rst_ypos", int'(ypos), 664);
    #2 rst = 1'b1;
    #1;
    check("async_rst_on", int'(on), 0);
    check("async_rst_ypos", int'(ypos), 0);
    check("async_rst_ready", int'(ready), 1);
    step(2);
    rst = 1'b0;
    step(2);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 7) == 0) fire = ~fire;
      hit = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) vsync_in = ~vsync_in;
      if ($urandom_range(0, 15) == 0) ship_xpos = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 15) == 0) ship_ypos = 11'($urandom_range(0, 600));
      step(1);
    end
    hit = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
